// File: rtl/matvec_pkg.sv
// matvec_pkg: shared types and helpers for the matrix-vector engine.
//   matvec_state_e : engine FSM states
//   DEF_DATA_W / DEF_ACC_W : default element / accumulator widths
//   lane_extract() : pull element k (width w) out of a memory word
package matvec_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 24;

  // Upper bounds for the lane helper; callers zero-extend into / truncate out of these.
  localparam int unsigned MAX_WORD_W = 512;
  localparam int unsigned MAX_LANE_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CALC,
    S_OUT,
    S_DONE
  } matvec_state_e;

  function automatic logic [MAX_LANE_W-1:0] lane_extract(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           k,
    input int unsigned           w
  );
    logic [MAX_WORD_W-1:0] sh;
    logic [MAX_LANE_W-1:0] mask;
    sh   = word >> (k * w);
    mask = (w >= MAX_LANE_W) ? '1 : ((MAX_LANE_W'(1) << w) - MAX_LANE_W'(1));
    return MAX_LANE_W'(sh) & mask;
  endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// mac_lane: one unsigned multiply-accumulate lane.
//   clk, rst : clock, synchronous active-high reset (acc -> 0)
//   clr      : clear accumulator (priority over en)
//   en       : acc <= acc + a*b, wrapping mod 2^ACC_W
//   a, b     : DATA_W-bit unsigned operands
//   acc      : ACC_W-bit accumulator
module mac_lane
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q, acc_d;

  always_comb begin
    prod  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// matvec_engine: fetches B and ROWS rows of A over an Avalon-MM read master,
// computes C[r] = sum_k A[r][k]*B[k] with ROWS parallel MAC lanes, then
// streams C[0..ROWS-1] on a valid/ready port.
//   clk, rst            : clock, synchronous active-high reset
//   start, base_addr    : job start pulse, word address of B (A row r at base+1+r)
//   busy, done          : job in progress, one-cycle completion pulse
//   address, read       : Avalon read request (held while waitrequest)
//   readdata, readdatavalid, waitrequest : Avalon read response / stall
//   res_valid, res_ready, res_data, res_idx : result stream
module matvec_engine
  import matvec_pkg::*;
#(
  parameter  int unsigned ROWS   = 8,
  parameter  int unsigned COLS   = 8,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned ACC_W  = DEF_ACC_W,
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned MEM_W  = COLS * DATA_W,
  localparam int unsigned IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [MEM_W-1:0]  readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [IDX_W-1:0]  res_idx
);

  localparam int unsigned N_W = $clog2(ROWS + 1);
  localparam int unsigned K_W = (COLS > 1) ? $clog2(COLS) : 1;

  matvec_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [MEM_W-1:0]  b_q, b_d;
  logic [MEM_W-1:0]  a_q [ROWS];
  logic [MEM_W-1:0]  a_d [ROWS];

  logic              acc_clr, acc_en;
  logic [DATA_W-1:0] lane_b;
  logic [DATA_W-1:0] lane_a [ROWS];
  logic [ACC_W-1:0]  acc    [ROWS];

  // Column k_q of B and of every buffered A row feeds the MAC lanes.
  always_comb begin
    lane_b = DATA_W'(lane_extract(MAX_WORD_W'(b_q), 32'(k_q), DATA_W));
    for (int unsigned r = 0; r < ROWS; r++) begin
      lane_a[r] = DATA_W'(lane_extract(MAX_WORD_W'(a_q[r]), 32'(k_q), DATA_W));
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (acc_en),
      .a   (lane_a[r]),
      .b   (lane_b),
      .acc (acc[r])
    );
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    k_d     = k_q;
    idx_d   = idx_q;
    b_d     = b_q;
    a_d     = a_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          n_d     = '0;
          k_d     = '0;
          idx_d   = '0;
          acc_clr = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!waitrequest) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (readdatavalid) begin
          // Word 0 is B; word n (n >= 1) is row n-1 of A.
          if (n_q == '0) begin
            b_d = readdata;
          end
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (n_q == N_W'(r + 1)) begin
              a_d[r] = readdata;
            end
          end
          if (n_q == N_W'(ROWS)) begin
            k_d     = '0;
            state_d = S_CALC;
          end else begin
            n_d     = n_q + N_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_CALC: begin
        acc_en = 1'b1;
        if (k_q == K_W'(COLS - 1)) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (idx_q == IDX_W'(ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      b_q     <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        a_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      a_q     <= a_d;
    end
  end

  always_comb begin
    res_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (idx_q == IDX_W'(r)) begin
        res_data = acc[r];
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign read      = (state_q == S_REQ);
  assign res_valid = (state_q == S_OUT);
  assign res_idx   = idx_q;
  assign address   = base_q + ADDR_W'(n_q);

endmodule
